// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, serial-out transmitter with frame_start/frame_last strobes.
// Define PISO_PARITY_EN to append an even-parity bit (extra PAR state) after the data bits.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_last
);

    localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_frame_start;
    logic             r_frame_last;
`ifdef PISO_PARITY_EN
    logic             r_par;
`endif

    logic             w_last_data;
    logic             w_final;
    logic             w_xfer;
    logic             w_in_first;
    logic [WIDTH-1:0] w_in_rest;
    logic             w_sh_bit;
    logic [WIDTH-1:0] w_sh_rest;
    logic [CW-1:0]    w_cnt_inc;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_ser_out_nxt;
    logic             w_ser_valid_nxt;
    logic             w_fs_nxt;
    logic             w_fl_nxt;

    // The shift register holds the bits not yet driven; the head bit is already on ser_out.
    assign w_in_first = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    assign w_in_rest  = MSB_FIRST ? (in_data << 1)   : (in_data >> 1);
    assign w_sh_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_sh_rest  = MSB_FIRST ? (r_shift << 1)   : (r_shift >> 1);
    assign w_cnt_inc  = r_cnt + 1'b1;

    assign w_last_data = (r_state == SHIFT) && (r_cnt == LAST_IDX);
`ifdef PISO_PARITY_EN
    assign w_final = (r_state == PAR);
`else
    assign w_final = w_last_data;
`endif
    assign in_ready = rst & ((r_state == IDLE) | w_final);
    assign w_xfer   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = SHIFT;
        end else if (w_final) begin
            w_state_nxt = IDLE;
`ifdef PISO_PARITY_EN
        end else if (w_last_data) begin
            w_state_nxt = PAR;
`endif
        end
    end

    always_comb begin
        w_shift_nxt     = '0;
        w_cnt_nxt       = '0;
        w_ser_out_nxt   = 1'b0;
        w_ser_valid_nxt = 1'b0;
        w_fs_nxt        = 1'b0;
        w_fl_nxt        = 1'b0;
        if (w_xfer) begin
            w_shift_nxt     = w_in_rest;
            w_ser_out_nxt   = w_in_first;
            w_ser_valid_nxt = 1'b1;
            w_fs_nxt        = 1'b1;
        end else if ((r_state == SHIFT) && !w_last_data) begin
            w_shift_nxt     = w_sh_rest;
            w_cnt_nxt       = w_cnt_inc;
            w_ser_out_nxt   = w_sh_bit;
            w_ser_valid_nxt = 1'b1;
`ifndef PISO_PARITY_EN
            w_fl_nxt        = (w_cnt_inc == LAST_IDX);
`endif
`ifdef PISO_PARITY_EN
        end else if (w_last_data) begin
            w_ser_out_nxt   = r_par;
            w_ser_valid_nxt = 1'b1;
            w_fl_nxt        = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift       <= '0;
            r_cnt         <= '0;
            r_ser_out     <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_last  <= 1'b0;
        end else begin
            r_shift       <= w_shift_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ser_out     <= w_ser_out_nxt;
            r_ser_valid   <= w_ser_valid_nxt;
            r_frame_start <= w_fs_nxt;
            r_frame_last  <= w_fl_nxt;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (w_xfer) begin
            r_par <= ^in_data;
        end
    end
`endif

    assign ser_out     = r_ser_out;
    assign ser_valid   = r_ser_valid;
    assign frame_start = r_frame_start;
    assign frame_last  = r_frame_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first instance plus an LSB-first instance, WIDTH=8.
module tb_piso_serializer;

    localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
    localparam int unsigned NB = W + 1;
`else
    localparam int unsigned NB = W;
`endif

    // Expected streams, transmission order from bit 8 downward; bit 0 is the parity bit.
    localparam logic [8:0] E_A5  = {8'b1010_0101, 1'b0};
    localparam logic [8:0] E_3C  = {8'b0011_1100, 1'b0};
    localparam logic [8:0] E_C3  = {8'b1100_0011, 1'b0};
    localparam logic [8:0] E_F0  = {8'b1111_0000, 1'b0};
    localparam logic [8:0] E_FF  = {8'b1111_1111, 1'b0};
    localparam logic [8:0] E_81  = {8'b1000_0001, 1'b0};
    localparam logic [8:0] E_07  = {8'b0000_0111, 1'b1};
    localparam logic [8:0] E_01L = {8'b1000_0000, 1'b1};
    localparam logic [8:0] E_80L = {8'b0000_0001, 1'b1};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] m_data = '0;
    logic         m_valid = 1'b0;
    logic         m_ready, m_ser, m_sv, m_fs, m_fl;
    logic [W-1:0] l_data = '0;
    logic         l_valid = 1'b0;
    logic         l_ready, l_ser, l_sv, l_fs, l_fl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(m_data), .in_valid(m_valid), .in_ready(m_ready),
        .ser_out(m_ser), .ser_valid(m_sv), .frame_start(m_fs), .frame_last(m_fl)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
        .ser_out(l_ser), .ser_valid(l_sv), .frame_start(l_fs), .frame_last(l_fl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input bit lsb, input int unsigned j, input logic [8:0] e);
        logic so, sv, fs, fl, rd;
        so = lsb ? l_ser   : m_ser;
        sv = lsb ? l_sv    : m_sv;
        fs = lsb ? l_fs    : m_fs;
        fl = lsb ? l_fl    : m_fl;
        rd = lsb ? l_ready : m_ready;
        check($sformatf("%s.b%0d.ser_out", tag, j + 1), so, e[8 - j]);
        check($sformatf("%s.b%0d.ser_valid", tag, j + 1), sv, 1'b1);
        check($sformatf("%s.b%0d.frame_start", tag, j + 1), fs, (j == 0));
        check($sformatf("%s.b%0d.frame_last", tag, j + 1), fl, (j == NB - 1));
        check($sformatf("%s.b%0d.in_ready", tag, j + 1), rd, (j == NB - 1));
    endtask

    task automatic check_idle(input string tag, input bit lsb, input logic exp_ready);
        check($sformatf("%s.idle.ser_valid", tag), lsb ? l_sv : m_sv, 1'b0);
        check($sformatf("%s.idle.ser_out", tag), lsb ? l_ser : m_ser, 1'b0);
        check($sformatf("%s.idle.frame_start", tag), lsb ? l_fs : m_fs, 1'b0);
        check($sformatf("%s.idle.frame_last", tag), lsb ? l_fl : m_fl, 1'b0);
        check($sformatf("%s.idle.in_ready", tag), lsb ? l_ready : m_ready, exp_ready);
    endtask

    task automatic run_frame(input string tag, input bit lsb, input logic [W-1:0] d, input logic [8:0] e);
        if (lsb) begin l_data = d; l_valid = 1'b1; end
        else     begin m_data = d; m_valid = 1'b1; end
        tick();
        l_valid = 1'b0;
        m_valid = 1'b0;
        for (int unsigned j = 0; j < NB; j++) begin
            check_bit(tag, lsb, j, e);
            tick();
        end
        check_idle(tag, lsb, 1'b1);
    endtask

    initial begin
        // Reset held for two edges
        tick();
        tick();
        check_idle("reset_m", 1'b0, 1'b0);
        check_idle("reset_l", 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("release.in_ready", m_ready, 1'b1);
        tick();

        run_frame("basic_A5", 1'b0, 8'hA5, E_A5);
        run_frame("lsb_01", 1'b1, 8'h01, E_01L);
        run_frame("lsb_80", 1'b1, 8'h80, E_80L);

        // Back-to-back: in_valid held, second word presented right after the first transfer
        m_data  = 8'h3C;
        m_valid = 1'b1;
        tick();
        m_data = 8'hC3;
        for (int unsigned i = 0; i < 2 * NB; i++) begin
            check_bit("b2b", 1'b0, i % NB, (i < NB) ? E_3C : E_C3);
            if (i == 2 * NB - 1) m_valid = 1'b0;
            tick();
        end
        check_idle("b2b", 1'b0, 1'b1);

        // Busy ignore: 8'h0F offered during bits 2..6 of 8'hF0
        m_data  = 8'hF0;
        m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        for (int unsigned j = 0; j < NB; j++) begin
            check_bit("busy", 1'b0, j, E_F0);
            if (j >= 1 && j <= 5) begin
                m_valid = 1'b1;
                m_data  = 8'h0F;
            end else begin
                m_valid = 1'b0;
            end
            tick();
        end
        check_idle("busy", 1'b0, 1'b1);

        // Asynchronous reset between edges after bit 3
        m_data  = 8'hFF;
        m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        for (int unsigned j = 0; j < 3; j++) begin
            check_bit("abort", 1'b0, j, E_FF);
            if (j < 2) tick();
        end
        #2;
        rst = 1'b0;
        #1;
        check_idle("abort_async", 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check_idle("abort_release", 1'b0, 1'b1);
        run_frame("after_rst_81", 1'b0, 8'h81, E_81);

        run_frame("frame_07", 1'b0, 8'h07, E_07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock.
- Provides framing strobes alongside the serial bit.
- Sits on the transmit side of a serial link. Its ser_out/ser_valid pair drives a downstream flip-flop sampling chain, which captures one bit per rising edge.

Parameters:
- WIDTH, 8, number of data bits per frame (>= 2)
- MSB_FIRST, 1, 1 = transmit in_data[WIDTH-1] first; 0 = transmit in_data[0] first

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- in_data  input  WIDTH  parallel word to transmit
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word this cycle
- ser_out  output  1  serial data bit (registered)
- ser_valid  output  1  ser_out carries a frame bit (registered)
- frame_start  output  1  high with the first bit of a frame (registered)
- frame_last  output  1  high with the final bit of a frame (registered)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; shift register, bit counter, ser_out, ser_valid, frame_start, frame_last all 0 immediately, without waiting for a clock edge.
  - in_ready forced 0 while rst=0.
- FSM states:
  - IDLE: no frame in progress.
  - SHIFT: data bits going out.
  - PAR: parity bit going out; exists only with the optional feature.
- Handshake:
  - Transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - in_ready is combinational: 1 when rst=1 and either state=IDLE, or state is on the final bit of the current frame (back-to-back support).
  - in_data is sampled only on a transfer. Changes to in_data while busy are ignored.
- Latency:
  - Transfer at edge k → first bit on ser_out with ser_valid=1 and frame_start=1 during the cycle after edge k.
  - Bits follow on consecutive cycles with no gaps.
  - Frame length: WIDTH cycles (WIDTH+1 with parity).
- Bit order:
  - MSB_FIRST=1: in_data[WIDTH-1] down to in_data[0].
  - MSB_FIRST=0: in_data[0] up to in_data[WIDTH-1].
- Counter:
  - Bit counter 0..WIDTH-1, width $clog2(WIDTH).
  - frame_last=1 when the final frame bit is driven.
- End of frame:
  - Transfer on the final-bit edge: next frame's first bit follows immediately, frame_start=1, ser_valid stays 1.
  - No transfer on the final-bit edge: state→IDLE, ser_valid=0, ser_out=0, frame_start=0, frame_last=0.
- IDLE outputs: ser_out held 0.
- in_valid=1 while busy (not final bit): no transfer, no effect on the frame.
- Reset mid-frame: frame aborted, no partial resumption. First transfer after release starts a fresh frame.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, state→PAR for one cycle.
  - ser_out = even parity (XOR of the WIDTH sampled data bits); ser_valid=1.
  - frame_last moves from the last data bit to the parity bit.
  - in_ready back-to-back window moves to the PAR cycle.
- Undefined: PAR state, parity logic and parity register are not compiled. Frame is exactly WIDTH bits.

Test Plan (WIDTH=8 unless noted):
- Basic MSB-first: reset 2 cycles, then in_data=8'hA5 with in_valid for 1 cycle.
  - Next 8 cycles: ser_out=1,0,1,0,0,1,0,1 with ser_valid=1.
  - frame_start on cycle 1 only, frame_last on cycle 8 only.
  - Cycle 9: ser_valid=0.
- LSB-first (MSB_FIRST=0): send 8'h01.
  - ser_out=1,0,0,0,0,0,0,0.
  - Then send 8'h80 → ser_out=0,0,0,0,0,0,0,1.
- Back-to-back: hold in_valid=1, present 8'h3C and then 8'hC3 (second word changed on the transfer edge).
  - 16 consecutive ser_valid=1 cycles: 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1.
  - frame_start on cycles 1 and 9; frame_last on cycles 8 and 16.
- Busy ignore: start 8'hF0, then drive in_valid=1 with in_data=8'h0F during bits 2–6.
  - Serial stream is unchanged (1,1,1,1,0,0,0,0).
  - in_ready=0 during bits 1–7, in_ready=1 on bit 8.
- Async reset mid-frame: pull rst=0 between edges after bit 3 of 8'hFF.
  - ser_valid, ser_out, frame_start, frame_last go 0 before the next edge; in_ready=0.
  - After release, 8'h81 transmits as 1,0,0,0,0,0,0,1 from frame_start.
- PISO_PARITY_EN defined:
  - 8'hA5 → 9 bits, last=0.
  - 8'h07 → 9 bits, last=1.
  - frame_last only on bit 9.
